// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with per-register busy
// scoreboard for RAW stall detection in the ID stage.
//
// Ports:
//   rf_in_clk   clock, all state updates on the rising edge
//   rf_in_rst   asynchronous active-high reset
//   read_ibus   NUM_RD x {re, raddr}, port 0 in the LSBs
//   read_obus   NUM_RD x rdata, port 0 in the LSBs
//   busy_obus   NUM_RD busy flags, bit k tracks raddr_k
//   write_ibus  NUM_WR x {we, waddr, wdata}, lane 0 in the LSBs
//   set_ibus    NUM_WR x {set, saddr}, marks saddr busy
//   flush_in    clears every busy bit on the next edge
//
// Optional feature macro: RF_BYPASS_EN (write-to-read forwarding with
// same-cycle busy masking). Undefined by default.
module reg_file_mp #(
    parameter int NUM_RD  = 4,
    parameter int NUM_WR  = 2,
    parameter int REG_NUM = 32,
    parameter int DW      = 32,
    parameter int AW      = $clog2(REG_NUM)
) (
    input  logic                         rf_in_clk,
    input  logic                         rf_in_rst,
    input  logic [NUM_RD*(1+AW)-1:0]     read_ibus,
    output logic [NUM_RD*DW-1:0]         read_obus,
    output logic [NUM_RD-1:0]            busy_obus,
    input  logic [NUM_WR*(1+AW+DW)-1:0]  write_ibus,
    input  logic [NUM_WR*(1+AW)-1:0]     set_ibus,
    input  logic                         flush_in
);

    localparam int RFW = 1 + AW;
    localparam int WFW = 1 + AW + DW;

    logic [DW-1:0]      regs_q [REG_NUM];
    logic [DW-1:0]      regs_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic [NUM_RD-1:0]  r_en;
    logic [AW-1:0]      r_addr [NUM_RD];

    logic [NUM_WR-1:0]  w_act;
    logic [AW-1:0]      w_addr [NUM_WR];
    logic [DW-1:0]      w_data [NUM_WR];

    logic [NUM_WR-1:0]  s_en;
    logic [AW-1:0]      s_addr [NUM_WR];

    logic [REG_NUM-1:0] wr_hit;
    logic [REG_NUM-1:0] set_hit;

    // Field unpacking
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            r_addr[k] = read_ibus[k*RFW +: AW];
            r_en[k]   = read_ibus[k*RFW + AW];
        end
        for (int j = 0; j < NUM_WR; j++) begin
            w_data[j] = write_ibus[j*WFW +: DW];
            w_addr[j] = write_ibus[j*WFW + DW +: AW];
            // A lane aimed at r0 is treated as idle everywhere.
            w_act[j]  = write_ibus[j*WFW + DW + AW] &&
                        (w_addr[j] != '0);
            s_addr[j] = set_ibus[j*RFW +: AW];
            s_en[j]   = set_ibus[j*RFW + AW] &&
                        (s_addr[j] != '0);
        end
    end

    // Array next state: lanes scanned in ascending order so the
    // highest-index (youngest) lane wins on collisions.
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            regs_d[r] = regs_q[r];
            wr_hit[r] = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_act[j] && (w_addr[j] == AW'(r))) begin
                    regs_d[r] = w_data[j];
                    wr_hit[r] = 1'b1;
                end
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard next state: flush > set > writeback clear > hold.
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            set_hit[r] = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (s_en[j] && (s_addr[j] == AW'(r))) begin
                    set_hit[r] = 1'b1;
                end
            end
        end
        for (int r = 0; r < REG_NUM; r++) begin
            if (flush_in) begin
                busy_d[r] = 1'b0;
            end else if (set_hit[r]) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge rf_in_clk or posedge rf_in_rst) begin
        if (rf_in_rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

`ifndef RF_BYPASS_EN
    // Read enables only gate forwarding, which is absent here.
    logic unused_re;
    assign unused_re = ^r_en;
`endif

    // Combinational read ports
    always_comb begin
        logic [DW-1:0] rd;
        logic          bz;
        logic          fwd;
        read_obus = '0;
        busy_obus = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd  = regs_q[r_addr[k]];
            bz  = busy_q[r_addr[k]];
            fwd = 1'b0;
`ifdef RF_BYPASS_EN
            if (r_en[k]) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_act[j] && (w_addr[j] == r_addr[k])) begin
                        rd  = w_data[j];
                        fwd = 1'b1;
                    end
                end
            end
`endif
            // Forwarded data is the producer's result, so no stall.
            if (fwd) begin
                bz = 1'b0;
            end
            if ((r_addr[k] == '0) || rf_in_rst) begin
                rd = '0;
                bz = 1'b0;
            end
            read_obus[k*DW +: DW] = rd;
            busy_obus[k]          = bz;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of reg_file_mp
// against a behavioural register/scoreboard model.
module tb_reg_file_mp;

    localparam int AR = 4;
    localparam int AWN = 2;
    localparam int AA = 5;
    localparam int AD = 32;

    localparam int BR = 6;
    localparam int BWN = 3;
    localparam int BN = 64;
    localparam int BA = 6;
    localparam int BD = 64;

    logic clk;
    logic rst;

    logic [AR*(1+AA)-1:0]      rd_a;
    logic [AR*AD-1:0]          rdo_a;
    logic [AR-1:0]             bz_a;
    logic [AWN*(1+AA+AD)-1:0]  wr_a;
    logic [AWN*(1+AA)-1:0]     st_a;
    logic                      fl_a;

    logic [BR*(1+BA)-1:0]      rd_b;
    logic [BR*BD-1:0]          rdo_b;
    logic [BR-1:0]             bz_b;
    logic [BWN*(1+BA+BD)-1:0]  wr_b;
    logic [BWN*(1+BA)-1:0]     st_b;
    logic                      fl_b;

    int n_cmp = 0;
    int n_err = 0;

    reg_file_mp u_dut (
        .rf_in_clk  (clk),
        .rf_in_rst  (rst),
        .read_ibus  (rd_a),
        .read_obus  (rdo_a),
        .busy_obus  (bz_a),
        .write_ibus (wr_a),
        .set_ibus   (st_a),
        .flush_in   (fl_a)
    );

    reg_file_mp #(
        .NUM_RD  (BR),
        .NUM_WR  (BWN),
        .REG_NUM (BN),
        .DW      (BD)
    ) u_big (
        .rf_in_clk  (clk),
        .rf_in_rst  (rst),
        .read_ibus  (rd_b),
        .read_obus  (rdo_b),
        .busy_obus  (bz_b),
        .write_ibus (wr_b),
        .set_ibus   (st_b),
        .flush_in   (fl_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_a = '0;
        wr_a = '0;
        st_a = '0;
        fl_a = 1'b0;
    endtask

    task automatic drv_rd(input int k, input logic re,
                          input logic [AA-1:0] a);
        rd_a[k*(1+AA) +: (1+AA)] = {re, a};
    endtask

    task automatic drv_wr(input int j, input logic we,
                          input logic [AA-1:0] a,
                          input logic [AD-1:0] d);
        wr_a[j*(1+AA+AD) +: (1+AA+AD)] = {we, a, d};
    endtask

    task automatic drv_set(input int j, input logic s,
                           input logic [AA-1:0] a);
        st_a[j*(1+AA) +: (1+AA)] = {s, a};
    endtask

    function automatic logic [AD-1:0] rdat(input int k);
        return rdo_a[k*AD +: AD];
    endfunction

    task automatic test_reset();
        logic [AD-1:0] got;
        idle();
        tick();
        rst = 1'b0;
        drv_wr(0, 1'b1, 5'd5, 32'h55);
        drv_set(1, 1'b1, 5'd6);
        tick();
        idle();
        drv_rd(0, 1'b0, 5'd5);
        drv_rd(1, 1'b0, 5'd6);
        drv_rd(2, 1'b1, 5'd5);
        drv_rd(3, 1'b1, 5'd6);
        #1;
        n_cmp++;
        if (rdat(0) !== 32'h55 || bz_a !== 4'b1010) begin
            n_err++;
            $display("FAIL stale_before_reset: rdata0=%h busy=%b want 55 1010",
                     rdat(0), bz_a);
        end
        #1;
        rst = 1'b1;
        #1;
        for (int k = 0; k < AR; k++) begin
            got = rdat(k);
            n_cmp++;
            if (got !== '0) begin
                n_err++;
                $display("FAIL reset_rdata%0d: got %h want 0", k, got);
            end
        end
        n_cmp++;
        if (bz_a !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0000", bz_a);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rdat(0) !== '0 || bz_a !== 4'b0000) begin
            n_err++;
            $display("FAIL after_reset_r5: rdata=%h busy=%b want 0 0000",
                     rdat(0), bz_a);
        end
    endtask

    task automatic test_collision();
        idle();
        drv_wr(0, 1'b1, 5'd3, 32'h11);
        drv_wr(1, 1'b1, 5'd3, 32'h22);
        tick();
        idle();
        drv_rd(0, 1'b0, 5'd3);
        #1;
        n_cmp++;
        if (rdat(0) !== 32'h22) begin
            n_err++;
            $display("FAIL collision_r3: got %h want 22", rdat(0));
        end
        drv_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        drv_rd(1, 1'b1, 5'd0);
        #1;
        n_cmp++;
        if (rdat(1) !== '0 || bz_a[1] !== 1'b0) begin
            n_err++;
            $display("FAIL r0_same_cycle: got %h/%b want 0/0",
                     rdat(1), bz_a[1]);
        end
        tick();
        idle();
        drv_rd(1, 1'b1, 5'd0);
        #1;
        n_cmp++;
        if (rdat(1) !== '0) begin
            n_err++;
            $display("FAIL r0_after_write: got %h want 0", rdat(1));
        end
    endtask

    task automatic test_bypass();
        logic [AD-1:0] exp_d;
        logic          exp_b;
        idle();
        drv_wr(0, 1'b1, 5'd7, 32'hA);
        drv_set(0, 1'b1, 5'd7);
        tick();
        idle();
        drv_wr(1, 1'b1, 5'd7, 32'hB);
        drv_rd(0, 1'b1, 5'd7);
        drv_rd(1, 1'b0, 5'd7);
        #1;
`ifdef RF_BYPASS_EN
        exp_d = 32'hB;
        exp_b = 1'b0;
`else
        exp_d = 32'hA;
        exp_b = 1'b1;
`endif
        n_cmp++;
        if (rdat(0) !== exp_d || bz_a[0] !== exp_b) begin
            n_err++;
            $display("FAIL bypass_same_cycle: got %h/%b want %h/%b",
                     rdat(0), bz_a[0], exp_d, exp_b);
        end
        n_cmp++;
        if (rdat(1) !== 32'hA || bz_a[1] !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_re0_port: got %h/%b want a/1",
                     rdat(1), bz_a[1]);
        end
        tick();
        idle();
        drv_rd(0, 1'b1, 5'd7);
        #1;
        n_cmp++;
        if (rdat(0) !== 32'hB || bz_a[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_after_edge: got %h/%b want b/0",
                     rdat(0), bz_a[0]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        drv_rd(0, 1'b0, 5'd9);
        drv_set(0, 1'b1, 5'd9);
        tick();
        drv_set(0, 1'b0, 5'd0);
        #1;
        n_cmp++;
        if (bz_a[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_set_edge1: got %b want 1", bz_a[0]);
        end
        tick();
        n_cmp++;
        if (bz_a[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_hold_edge2: got %b want 1", bz_a[0]);
        end
        drv_wr(1, 1'b1, 5'd9, 32'h99);
        tick();
        drv_wr(1, 1'b0, 5'd0, 32'h0);
        #1;
        n_cmp++;
        if (bz_a[0] !== 1'b0 || rdat(0) !== 32'h99) begin
            n_err++;
            $display("FAIL sb_wb_edge3: got %b/%h want 0/99",
                     bz_a[0], rdat(0));
        end
        drv_set(1, 1'b1, 5'd9);
        drv_wr(0, 1'b1, 5'd9, 32'h77);
        tick();
        drv_set(1, 1'b0, 5'd0);
        drv_wr(0, 1'b0, 5'd0, 32'h0);
        #1;
        n_cmp++;
        if (bz_a[0] !== 1'b1 || rdat(0) !== 32'h77) begin
            n_err++;
            $display("FAIL sb_set_beats_wb: got %b/%h want 1/77",
                     bz_a[0], rdat(0));
        end
        drv_set(0, 1'b1, 5'd0);
        tick();
        drv_set(0, 1'b0, 5'd0);
        drv_rd(1, 1'b0, 5'd0);
        #1;
        n_cmp++;
        if (bz_a[1] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_set_r0: got %b want 0", bz_a[1]);
        end
    endtask

    task automatic test_flush();
        idle();
        drv_set(0, 1'b1, 5'd4);
        drv_set(1, 1'b1, 5'd6);
        tick();
        drv_set(0, 1'b1, 5'd8);
        drv_set(1, 1'b0, 5'd0);
        tick();
        idle();
        drv_rd(0, 1'b0, 5'd4);
        drv_rd(1, 1'b0, 5'd6);
        drv_rd(2, 1'b0, 5'd8);
        drv_rd(3, 1'b0, 5'd10);
        #1;
        n_cmp++;
        if (bz_a !== 4'b0111) begin
            n_err++;
            $display("FAIL flush_pre: got %b want 0111", bz_a);
        end
        fl_a = 1'b1;
        drv_set(0, 1'b1, 5'd10);
        tick();
        fl_a = 1'b0;
        drv_set(0, 1'b0, 5'd0);
        #1;
        n_cmp++;
        if (bz_a !== 4'b0000) begin
            n_err++;
            $display("FAIL flush_post: got %b want 0000", bz_a);
        end
    endtask

    task automatic test_sweep();
        logic [BD-1:0] m_regs [BN];
        logic          m_busy [BN];
        logic          we [BWN];
        logic [BA-1:0] wa [BWN];
        logic [BD-1:0] wd [BWN];
        logic          se [BWN];
        logic [BA-1:0] sa [BWN];
        logic          re [BR];
        logic [BA-1:0] ra [BR];
        logic          fl;
        logic [BD-1:0] ed;
        logic          eb;
        logic [BD-1:0] gd;
        int            bad;
        for (int r = 0; r < BN; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        bad = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int j = 0; j < BWN; j++) begin
                we[j] = ($urandom_range(0, 2) != 0);
                wa[j] = BA'($urandom_range(0, 3) == 0 ?
                        $urandom_range(0, 3) : $urandom_range(0, BN-1));
                wd[j] = {$urandom, $urandom};
                se[j] = ($urandom_range(0, 3) == 0);
                sa[j] = BA'($urandom_range(0, BN-1));
                wr_b[j*(1+BA+BD) +: (1+BA+BD)] = {we[j], wa[j], wd[j]};
                st_b[j*(1+BA) +: (1+BA)] = {se[j], sa[j]};
            end
            for (int k = 0; k < BR; k++) begin
                re[k] = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 1) == 0)
                    ra[k] = wa[$urandom_range(0, BWN-1)];
                else
                    ra[k] = BA'($urandom_range(0, BN-1));
                rd_b[k*(1+BA) +: (1+BA)] = {re[k], ra[k]};
            end
            fl = ($urandom_range(0, 49) == 0);
            fl_b = fl;
            #1;
            for (int k = 0; k < BR; k++) begin
                ed = m_regs[ra[k]];
                eb = m_busy[ra[k]];
`ifdef RF_BYPASS_EN
                if (re[k] && ra[k] != 0) begin
                    for (int j = 0; j < BWN; j++) begin
                        if (we[j] && wa[j] == ra[k]) begin
                            ed = wd[j];
                            eb = 1'b0;
                        end
                    end
                end
`endif
                if (ra[k] == 0) begin
                    ed = '0;
                    eb = 1'b0;
                end
                gd = rdo_b[k*BD +: BD];
                n_cmp++;
                if (gd !== ed || bz_b[k] !== eb) begin
                    n_err++;
                    if (bad < 10)
                        $display("FAIL sweep_c%0d_p%0d r%0d: got %h/%b want %h/%b",
                                 c, k, ra[k], gd, bz_b[k], ed, eb);
                    bad++;
                end
            end
            @(posedge clk);
            #1;
            for (int j = 0; j < BWN; j++)
                if (we[j] && wa[j] != 0) m_regs[wa[j]] = wd[j];
            for (int j = 0; j < BWN; j++)
                if (we[j] && wa[j] != 0) m_busy[wa[j]] = 1'b0;
            for (int j = 0; j < BWN; j++)
                if (se[j] && sa[j] != 0) m_busy[sa[j]] = 1'b1;
            if (fl)
                for (int r = 0; r < BN; r++) m_busy[r] = 1'b0;
        end
        rd_b = '0;
        wr_b = '0;
        st_b = '0;
        fl_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_b = '0;
        wr_b = '0;
        st_b = '0;
        fl_b = 1'b0;
        test_reset();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
